// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings and defaults for the MIPS load/store unit
package mips_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam int MEM_WORDS_DEF = 100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - byte/halfword lane extract-extend and store merge
module lsu_lane
   import mips_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b0
)
(
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_off,
   input  logic        i_unsigned,
   output logic [31:0] o_rdata,
   output logic [31:0] o_merged
);

   logic [1:0]  w_byte_lane;
   logic        w_half_lane;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // big-endian memory puts byte 0 in the top lane, so the lane index flips
   assign w_byte_lane = BIG_ENDIAN ? ~i_off : i_off;
   assign w_half_lane = BIG_ENDIAN ? ~i_off[1] : i_off[1];
   assign w_byte      = i_word[8*w_byte_lane +: 8];
   assign w_half      = i_word[16*w_half_lane +: 16];

   // load path: pick the addressed lane and sign- or zero-extend it
   always_comb begin
      o_rdata = i_word;
      case (i_size)
         SZ_BYTE: o_rdata = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
         SZ_HALF: o_rdata = {{16{w_half[15] & ~i_unsigned}}, w_half};
         default: o_rdata = i_word;
      endcase
   end

   // store path: replace only the addressed lane of the old word
   always_comb begin
      o_merged = i_word;
      case (i_size)
         SZ_BYTE: o_merged[8*w_byte_lane +: 8]   = i_wdata[7:0];
         SZ_HALF: o_merged[16*w_half_lane +: 16] = i_wdata[15:0];
         default: o_merged = i_wdata;
      endcase
   end

endmodule

// File: rtl/mips_lsu.sv
// rtl/mips_lsu.sv - load/store unit between MIPS datapath and word-addressed data memory
module mips_lsu
   import mips_pkg::*;
#(
   parameter int MEM_WORDS  = MEM_WORDS_DEF,
   parameter bit BIG_ENDIAN = 1'b0
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_cpu_req,
   input  logic        i_cpu_we,
   input  logic [1:0]  i_cpu_size,
   input  logic        i_cpu_unsigned,
   input  logic [31:0] i_cpu_addr,
   input  logic [31:0] i_cpu_wdata,
   output logic        o_cpu_busy,
   output logic        o_cpu_done,
   output logic [31:0] o_cpu_rdata,
   output logic        o_cpu_err,
   output logic        o_mem_w_en,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_w_data,
   input  logic [31:0] i_mem_r_data
);

   lsu_state_t  r_state;
   lsu_state_t  w_next;
   logic        r_we;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic [1:0]  r_off;
   logic [31:0] r_wdata;
   logic        r_err;
   logic [31:0] r_old;
   logic [31:0] r_rdata;
   logic [31:0] r_mem_addr;
   logic        w_bad;
   logic [31:0] w_lane_word;
   logic [31:0] w_lane_rdata;
   logic [31:0] w_merged;

   assign w_bad = (i_cpu_size == 2'd3)
               || ((i_cpu_size == SZ_HALF) && i_cpu_addr[0])
               || ((i_cpu_size == SZ_WORD) && (i_cpu_addr[1:0] != 2'b00))
               || ({2'b00, i_cpu_addr[31:2]} >= 32'(MEM_WORDS));

   // RD extracts from live memory data; WR merges into the word captured in RD
   assign w_lane_word = (r_state == WR) ? r_old : i_mem_r_data;

   lsu_lane #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
      .i_word     (w_lane_word),
      .i_wdata    (r_wdata),
      .i_size     (r_size),
      .i_off      (r_off),
      .i_unsigned (r_unsigned),
      .o_rdata    (w_lane_rdata),
      .o_merged   (w_merged)
   );

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // next-state: errors skip memory, sub-word stores need a read before the write
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (i_cpu_req) begin
               if (w_bad)                                    w_next = RESP;
               else if (!i_cpu_we || i_cpu_size != SZ_WORD)  w_next = RD;
               else                                          w_next = WR;
            end
         end
         RD:      w_next = r_we ? WR : RESP;
         WR:      w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // request capture at accept, old-word capture and load result in RD
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_we       <= 1'b0;
         r_size     <= SZ_BYTE;
         r_unsigned <= 1'b0;
         r_off      <= 2'b00;
         r_wdata    <= 32'd0;
         r_err      <= 1'b0;
         r_old      <= 32'd0;
         r_rdata    <= 32'd0;
         r_mem_addr <= 32'd0;
      end else begin
         if (r_state == IDLE && i_cpu_req) begin
            r_we       <= i_cpu_we;
            r_size     <= i_cpu_size;
            r_unsigned <= i_cpu_unsigned;
            r_off      <= i_cpu_addr[1:0];
            r_wdata    <= i_cpu_wdata;
            r_err      <= w_bad;
            r_mem_addr <= {2'b00, i_cpu_addr[31:2]};
         end
         if (r_state == RD) begin
            r_old <= i_mem_r_data;
            if (!r_we) r_rdata <= w_lane_rdata;
         end
      end
   end

   assign o_cpu_busy   = (r_state != IDLE);
   assign o_cpu_done   = (r_state == RESP);
   assign o_cpu_err    = (r_state == RESP) && r_err;
   assign o_cpu_rdata  = r_rdata;
   assign o_mem_w_en   = (r_state == WR);
   assign o_mem_addr   = r_mem_addr;
   assign o_mem_w_data = o_mem_w_en ? w_merged : 32'd0;

endmodule
